// File: rtl/mem_wb_stage.sv
// MEM stage controller and MEM/WB register with a req/ack data-memory port.
// Define MEM_WB_TIMEOUT_EN to compile in the access watchdog and mem_err.
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_inc_out_mem,
    input  logic [15:0] bs_out_mem,
    input  logic [15:0] alu_out_mem,
    input  logic [1:0]  m8_sel_mem,
    input  logic [2:0]  m2_out_mem,
    input  logic [15:0] mem_wr_data_mem,
    input  logic        mem_wr_en_mem,
    input  logic        mem_rd_en_mem,
    input  logic        reg_wr_en_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        stall_mem,
    output logic [15:0] wb_data_wb,
    output logic [2:0]  wb_rd_wb,
    output logic        wb_en_wb,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] lbuf_q, lbuf_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic        wb_en_q, wb_en_d;
    logic        mem_op;
    logic        capture;
    logic [15:0] wb_mux;

`ifdef MEM_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        unique case (m8_sel_mem)
            2'b00:   wb_mux = alu_out_mem;
            2'b01:   wb_mux = lbuf_q;
            2'b10:   wb_mux = pc_inc_out_mem;
            default: wb_mux = bs_out_mem;
        endcase
    end

    always_comb begin
        mem_op    = mem_rd_en_mem | mem_wr_en_mem;
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lbuf_d    = lbuf_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_en_d   = wb_en_q;
        stall_mem = 1'b0;
        capture   = 1'b0;
`ifdef MEM_WB_TIMEOUT_EN
        cnt_d = cnt_q;
        err_d = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall_mem = 1'b1;
                    wb_en_d   = 1'b0;
                    req_d     = 1'b1;
                    we_d      = mem_wr_en_mem;
                    addr_d    = alu_out_mem;
                    wdata_d   = mem_wr_data_mem;
                    state_d   = ACCESS;
`ifdef MEM_WB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end else begin
                    capture = 1'b1;
                end
            end
            ACCESS: begin
                stall_mem = 1'b1;
                wb_en_d   = 1'b0;
                if (dmem_ack) begin
                    lbuf_d  = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = COMPLETE;
                end
`ifdef MEM_WB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CW'(1);
                    // Abort on the edge where the count reaches the limit
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        req_d   = 1'b0;
                        lbuf_d  = 16'h0000;
                        err_d   = 1'b1;
                        state_d = COMPLETE;
                    end
                end
`endif
            end
            COMPLETE: begin
                capture = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            wb_data_d = wb_mux;
            wb_rd_d   = m2_out_mem;
            wb_en_d   = reg_wr_en_mem & ~mem_wr_en_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            lbuf_q    <= 16'h0000;
            wb_data_q <= 16'h0000;
            wb_rd_q   <= 3'd0;
            wb_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lbuf_q    <= lbuf_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_en_q   <= wb_en_d;
        end
    end

`ifdef MEM_WB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_data_wb = wb_data_q;
    assign wb_rd_wb   = wb_rd_q;
    assign wb_en_wb   = wb_en_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; the timeout scenario runs only when
// MEM_WB_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 4).
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_inc_out_mem;
    logic [15:0] bs_out_mem;
    logic [15:0] alu_out_mem;
    logic [1:0]  m8_sel_mem;
    logic [2:0]  m2_out_mem;
    logic [15:0] mem_wr_data_mem;
    logic        mem_wr_en_mem;
    logic        mem_rd_en_mem;
    logic        reg_wr_en_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        stall_mem;
    logic [15:0] wb_data_wb;
    logic [2:0]  wb_rd_wb;
    logic        wb_en_wb;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_inc_out_mem  (pc_inc_out_mem),
        .bs_out_mem      (bs_out_mem),
        .alu_out_mem     (alu_out_mem),
        .m8_sel_mem      (m8_sel_mem),
        .m2_out_mem      (m2_out_mem),
        .mem_wr_data_mem (mem_wr_data_mem),
        .mem_wr_en_mem   (mem_wr_en_mem),
        .mem_rd_en_mem   (mem_rd_en_mem),
        .reg_wr_en_mem   (reg_wr_en_mem),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .stall_mem       (stall_mem),
        .wb_data_wb      (wb_data_wb),
        .wb_rd_wb        (wb_rd_wb),
        .wb_en_wb        (wb_en_wb),
        .mem_err         (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_nop();
        pc_inc_out_mem  = 16'h0000;
        bs_out_mem      = 16'h0000;
        alu_out_mem     = 16'h0000;
        m8_sel_mem      = 2'b00;
        m2_out_mem      = 3'd0;
        mem_wr_data_mem = 16'h0000;
        mem_wr_en_mem   = 1'b0;
        mem_rd_en_mem   = 1'b0;
        reg_wr_en_mem   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 16'h0000;
        drive_nop();
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== 34'h0) begin
            errors++;
            $display("FAIL reset_dmem: got %b %b %h %h want 0 0 0000 0000",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        checks++;
        if ({wb_data_wb, wb_rd_wb, wb_en_wb, mem_err, stall_mem} !== 22'h0) begin
            errors++;
            $display("FAIL reset_wb: got data=%h rd=%0d en=%b err=%b stall=%b want zeros",
                     wb_data_wb, wb_rd_wb, wb_en_wb, mem_err, stall_mem);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_alu();
        @(posedge clk);
        #1;
        m8_sel_mem    = 2'b00;
        alu_out_mem   = 16'h1234;
        bs_out_mem    = 16'h5A5A;
        m2_out_mem    = 3'd3;
        reg_wr_en_mem = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall: got %b want 0", stall_mem);
        end
        @(negedge clk);
        checks++;
        if (wb_data_wb !== 16'h1234 || wb_rd_wb !== 3'd3 || wb_en_wb !== 1'b1) begin
            errors++;
            $display("FAIL alu_wb: got %h/%0d/%b want 1234/3/1",
                     wb_data_wb, wb_rd_wb, wb_en_wb);
        end
        m8_sel_mem = 2'b11;
        m2_out_mem = 3'd4;
        @(negedge clk);
        checks++;
        if (wb_data_wb !== 16'h5A5A || wb_rd_wb !== 3'd4 || stall_mem !== 1'b0) begin
            errors++;
            $display("FAIL shift_wb: got %h/%0d stall=%b want 5a5a/4 stall=0",
                     wb_data_wb, wb_rd_wb, stall_mem);
        end
        drive_nop();
        @(negedge clk);
    endtask

    task automatic test_load_then_pc();
        int stalls = 0;
        int pulses = 0;
        @(posedge clk);
        #1;
        mem_rd_en_mem = 1'b1;
        alu_out_mem   = 16'h0040;
        m8_sel_mem    = 2'b01;
        m2_out_mem    = 3'd5;
        reg_wr_en_mem = 1'b1;
        @(negedge clk);
        stalls += int'(stall_mem);
        checks++;
        if (dmem_req !== 1'b0 || stall_mem !== 1'b1) begin
            errors++;
            $display("FAIL load_c0: got req=%b stall=%b want 0 1", dmem_req, stall_mem);
        end
        @(negedge clk);
        stalls += int'(stall_mem);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL load_req: got req=%b we=%b addr=%h want 1 0 0040",
                     dmem_req, dmem_we, dmem_addr);
        end
        @(negedge clk);
        stalls += int'(stall_mem);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hBEEF;
        @(posedge clk);
        #1 dmem_ack = 1'b0;
        dmem_rdata = 16'h0000;
        @(negedge clk);
        stalls += int'(stall_mem);
        pulses += int'(wb_en_wb);
        checks++;
        if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
            errors++;
            $display("FAIL load_complete: got req=%b stall=%b want 0 0",
                     dmem_req, stall_mem);
        end
        @(negedge clk);
        pulses += int'(wb_en_wb);
        checks++;
        if (wb_data_wb !== 16'hBEEF || wb_rd_wb !== 3'd5 || wb_en_wb !== 1'b1) begin
            errors++;
            $display("FAIL load_wb: got %h/%0d/%b want beef/5/1",
                     wb_data_wb, wb_rd_wb, wb_en_wb);
        end
        checks++;
        if (stalls != 3) begin
            errors++;
            $display("FAIL load_stall_cycles: got %0d want 3", stalls);
        end
        drive_nop();
        m8_sel_mem     = 2'b10;
        pc_inc_out_mem = 16'h0021;
        m2_out_mem     = 3'd6;
        reg_wr_en_mem  = 1'b1;
        @(negedge clk);
        pulses += int'(wb_en_wb);
        checks++;
        if (wb_data_wb !== 16'h0021 || wb_rd_wb !== 3'd6 || wb_en_wb !== 1'b1) begin
            errors++;
            $display("FAIL pc_wb: got %h/%0d/%b want 0021/6/1",
                     wb_data_wb, wb_rd_wb, wb_en_wb);
        end
        drive_nop();
        @(negedge clk);
        pulses += int'(wb_en_wb);
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL wb_en_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_store();
        @(posedge clk);
        #1;
        mem_rd_en_mem   = 1'b1;
        mem_wr_en_mem   = 1'b1;
        alu_out_mem     = 16'h0010;
        mem_wr_data_mem = 16'hA5A5;
        m8_sel_mem      = 2'b01;
        m2_out_mem      = 3'd2;
        reg_wr_en_mem   = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b1 || wb_en_wb !== 1'b0) begin
            errors++;
            $display("FAIL store_c0: got stall=%b en=%b want 1 0", stall_mem, wb_en_wb);
        end
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 16'h0010 ||
            dmem_wdata !== 16'hA5A5 || wb_en_wb !== 1'b0) begin
            errors++;
            $display("FAIL store_req: got req=%b we=%b addr=%h wd=%h en=%b want 1 1 0010 a5a5 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_en_wb);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h1111;
        @(posedge clk);
        #1 dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || stall_mem !== 1'b0 || wb_en_wb !== 1'b0) begin
            errors++;
            $display("FAIL store_complete: got req=%b stall=%b en=%b want 0 0 0",
                     dmem_req, stall_mem, wb_en_wb);
        end
        @(negedge clk);
        checks++;
        if (wb_en_wb !== 1'b0 || wb_data_wb !== 16'h1111) begin
            errors++;
            $display("FAIL store_wb: got en=%b data=%h want 0 1111", wb_en_wb, wb_data_wb);
        end
        drive_nop();
        dmem_rdata = 16'h0000;
        @(negedge clk);
    endtask

`ifdef MEM_WB_TIMEOUT_EN
    task automatic test_timeout();
        int high = 0;
        bit seen = 1'b0;
        @(posedge clk);
        #1;
        mem_rd_en_mem = 1'b1;
        alu_out_mem   = 16'h0100;
        m8_sel_mem    = 2'b01;
        m2_out_mem    = 3'd7;
        reg_wr_en_mem = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmem_req === 1'b1) begin
                high++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        checks++;
        if (high != 4) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d want 4", high);
        end
        checks++;
        if (mem_err !== 1'b1 || stall_mem !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: got err=%b stall=%b want 1 0", mem_err, stall_mem);
        end
        @(negedge clk);
        drive_nop();
        checks++;
        if (wb_data_wb !== 16'h0000 || wb_en_wb !== 1'b1 || wb_rd_wb !== 3'd7) begin
            errors++;
            $display("FAIL timeout_wb: got %h/%b/%0d want 0000/1/7",
                     wb_data_wb, wb_en_wb, wb_rd_wb);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b req=%b want 1 0", mem_err, dmem_req);
        end
    endtask
`endif

    task automatic test_reset_mid_access();
        @(posedge clk);
        #1;
        mem_rd_en_mem = 1'b1;
        alu_out_mem   = 16'h0080;
        m8_sel_mem    = 2'b01;
        m2_out_mem    = 3'd1;
        reg_wr_en_mem = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 16'h0080) begin
            errors++;
            $display("FAIL rst_pre: got req=%b addr=%h want 1 0080", dmem_req, dmem_addr);
        end
        #1 rst_n = 1'b0;
        drive_nop();
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== 34'h0 ||
            {wb_data_wb, wb_rd_wb, wb_en_wb, mem_err, stall_mem} !== 22'h0) begin
            errors++;
            $display("FAIL rst_async: req=%b addr=%h wb=%h/%0d/%b err=%b stall=%b want zeros",
                     dmem_req, dmem_addr, wb_data_wb, wb_rd_wb, wb_en_wb,
                     mem_err, stall_mem);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hDEAD;
        @(posedge clk);
        #1 dmem_ack = 1'b0;
        dmem_rdata = 16'h0000;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: got req=%b stall=%b want 0 0", dmem_req, stall_mem);
        end
        m8_sel_mem    = 2'b01;
        m2_out_mem    = 3'd1;
        reg_wr_en_mem = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_data_wb !== 16'h0000 || wb_en_wb !== 1'b1 || wb_rd_wb !== 3'd1) begin
            errors++;
            $display("FAIL late_ack_lbuf: got %h/%b/%0d want 0000/1/1",
                     wb_data_wb, wb_en_wb, wb_rd_wb);
        end
        drive_nop();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_then_pc();
        test_store();
`ifdef MEM_WB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-stage controller and MEM/WB pipeline register. It consumes the EX/MEM register outputs and performs loads and stores against a multi-cycle data memory using a req/ack handshake. While an access is outstanding it stalls the upstream pipeline. It registers the selected write-back value, destination register and write enable for the register file.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: ACCESS-state cycles without `dmem_ack` before abort (used only with the watchdog compiled in).

Ports:
- clk  input  1  pipeline clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- pc_inc_out_mem  input  16  PC+1 of the instruction in MEM.
- bs_out_mem  input  16  barrel-shifter result.
- alu_out_mem  input  16  ALU result; also the memory address.
- m8_sel_mem  input  2  write-back select: 00 ALU, 01 load data, 10 PC+1, 11 shifter.
- m2_out_mem  input  3  destination register index.
- mem_wr_data_mem  input  16  store data.
- mem_wr_en_mem  input  1  store request.
- mem_rd_en_mem  input  1  load request.
- reg_wr_en_mem  input  1  instruction writes the register file.
- dmem_req  output  1  memory request (registered).
- dmem_we  output  1  1 = write, 0 = read (registered).
- dmem_addr  output  16  registered address.
- dmem_wdata  output  16  registered store data.
- dmem_ack  input  1  one-cycle completion pulse from memory.
- dmem_rdata  input  16  read data, valid with `dmem_ack`.
- stall_mem  output  1  freezes PC, IF/ID, ID/EX and EX/MEM (combinational).
- wb_data_wb  output  16  write-back value.
- wb_rd_wb  output  3  write-back register index.
- wb_en_wb  output  1  register-file write enable.
- mem_err  output  1  sticky access-timeout flag.

## Operation
- mem_op = `mem_rd_en_mem | mem_wr_en_mem`. If both are asserted, the access is a store and load data is not used.
- FSM states are IDLE, ACCESS and COMPLETE.
- **IDLE**
  - no mem_op: `stall_mem` = 0; the WB register captures the current instruction at posedge.
  - mem_op: `stall_mem` = 1 and `wb_en_wb` <= 0 (bubble).
  - at the same posedge: `dmem_req` <= 1, `dmem_we` <= `mem_wr_en_mem`, `dmem_addr` <= `alu_out_mem`, `dmem_wdata` <= `mem_wr_data_mem`; next state ACCESS.
- **ACCESS**
  - `stall_mem` = 1 and `wb_en_wb` <= 0.
  - on `dmem_ack`: latch `dmem_rdata` into the load buffer, `dmem_req` <= 0; next state COMPLETE.
- **COMPLETE**
  - `stall_mem` = 0; the WB register captures the instruction using the load buffer for select 01; next state IDLE.
- WB capture:
  - `wb_data_wb` <= mux(`m8_sel_mem`).
  - `wb_rd_wb` <= `m2_out_mem`.
  - `wb_en_wb` <= `reg_wr_en_mem` & ~(store).
- Upstream inputs are held stable by `stall_mem`. The block relies on this and does not re-register them.
- `dmem_ack` is ignored outside ACCESS, including a late ack from an access aborted by reset.
- Reset (asynchronous, any state):
  - state IDLE.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` = 0.
  - `wb_data_wb` = 0, `wb_rd_wb` = 0, `wb_en_wb` = 0.
  - `mem_err` = 0, load buffer = 0, timeout counter = 0.
- With no mem_op present, reset releases with `stall_mem` = 0.

## Timing
- Non-memory instruction: 1 cycle, values visible on `wb_*` after the next posedge, no stall.
- Memory instruction with ack in the first ACCESS cycle: 3 cycles (IDLE, ACCESS, COMPLETE), `stall_mem` high for 2 cycles.
- Each extra wait cycle before ack adds 1 cycle.
- `dmem_req` rises one cycle after the instruction enters MEM. It falls on the posedge that samples `dmem_ack`.
- Back-to-back memory instructions each take their own full IDLE/ACCESS/COMPLETE sequence. `dmem_req` is low for at least 2 cycles between requests.

## Configuration
- `MEM_WB_TIMEOUT_EN` defined:
  - a counter, width $clog2(TIMEOUT_CYCLES+1), clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - when it reaches TIMEOUT_CYCLES: `dmem_req` <= 0, load buffer <= 16'h0000, `mem_err` <= 1 (sticky until reset), next state COMPLETE.
  - an ack arriving in the same cycle as the timeout takes priority over the timeout.
- `MEM_WB_TIMEOUT_EN` undefined:
  - there is no counter; ACCESS waits indefinitely and `mem_err` is tied to 0.

## Test plan
- ALU op (`m8_sel_mem`=00, `alu_out_mem`=16'h1234, `m2_out_mem`=3, `reg_wr_en_mem`=1) -> next cycle `wb_data_wb`=16'h1234, `wb_rd_wb`=3, `wb_en_wb`=1; `stall_mem` never asserted.
- Load at addr 16'h0040, ack 2 cycles after `dmem_req` with rdata 16'hBEEF -> `dmem_addr`=16'h0040, `dmem_we`=0, `stall_mem` high 3 cycles, `wb_data_wb`=16'hBEEF, `wb_en_wb` pulses once.
- Store of 16'hA5A5 to 16'h0010 with rd and wr both asserted, ack immediate -> `dmem_we`=1, `dmem_wdata`=16'hA5A5, `wb_en_wb`=0 throughout.
- Reset pulled low mid-ACCESS, then ack asserted after release -> `dmem_req`=0 and all outputs 0 immediately; the late ack is ignored and the state remains IDLE.
- With `MEM_WB_TIMEOUT_EN` and TIMEOUT_CYCLES=4, load never acked -> `dmem_req` drops after 4 ACCESS cycles, `mem_err`=1 and stays 1, `wb_data_wb`=16'h0000.
- PC+1 select (`m8_sel_mem`=10, `pc_inc_out_mem`=16'h0021) immediately after a load -> load result written first, then 16'h0021 on the next cycle, no lost or duplicated `wb_en_wb`.
